mul_add_shift_seq: RTL

Clocked, parametrised add-shift multiplier with a start/busy/done handshake. It is the successor to the combinational-loop 4-bit multiplier and has the following improvements:
- WIDTH-generic operands.
- One partial-product iteration per clock.
- Optional two's-complement mode.
- Zero-operand early exit.
It sits beside the datapath as a multi-cycle functional unit driven by a simple controller.

---
 rtl/mul_add_shift_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mul_add_shift_seq.sv
// ---------------------------------------------------------------------------
// mul_add_shift_seq
//   Sequential add-shift multiplier. One partial product is accumulated per
//   clock, so a nonzero multiply takes WIDTH RUN cycles. A zero operand skips
//   RUN entirely. In two's-complement mode the magnitudes are multiplied and
//   the sign is applied to the final product.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts any operation in flight)
//   start  request, sampled only in IDLE
//   tc     1 = signed operands, 0 = unsigned (sampled with start)
//   a, b   multiplicand / multiplier (sampled with start)
//   prod   registered 2*WIDTH-bit product, held until the next result
//   busy   high whenever the unit is not IDLE
//   done   one-cycle pulse while prod presents a freshly written result
// ---------------------------------------------------------------------------
module mul_add_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_prod;

  logic                 w_zero;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod_final;

  // Operand conditioning. The unsigned reading of -a is the magnitude, which
  // also holds for the most negative value (it maps to 2^(WIDTH-1)).
  assign w_a_mag = (tc && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (tc && b[WIDTH-1]) ? -b : b;
  assign w_zero  = (a == '0) || (b == '0);
  assign w_last  = (r_count == CNT_W'(1));

  // One add-shift step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift right with the carry entering
  // at the top.
  assign w_addend     = r_mplr[0] ? r_mcand : '0;
  assign w_sum        = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next   = (2*WIDTH)'({w_sum, r_acc[WIDTH-1:0]} >> 1);
  assign w_prod_final = r_neg ? -w_acc_next : w_acc_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  assign prod = r_prod;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_a_mag;
            r_mplr  <= w_b_mag;
            r_neg   <= tc & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH);
            // Early exit publishes zero directly; the sign is irrelevant.
            if (w_zero) begin
              r_prod <= '0;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_mplr  <= r_mplr >> 1;
          r_count <= r_count - CNT_W'(1);
          if (w_last) begin
            r_prod <= w_prod_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
